// File: rtl/scalu_pkg.sv
// scalu_pkg: shared definitions for the scalar ALU pipe.
//   - funct3 codes and op-field bit positions
//   - exception cause codes
//   - fixed-width status part of the result bundle
//   - illegal-op decode helper
package scalu_pkg;

  localparam logic [2:0] F3_ADD  = 3'b000;
  localparam logic [2:0] F3_SLL  = 3'b001;
  localparam logic [2:0] F3_SLT  = 3'b010;
  localparam logic [2:0] F3_SLTU = 3'b011;
  localparam logic [2:0] F3_XOR  = 3'b100;
  localparam logic [2:0] F3_SR   = 3'b101;
  localparam logic [2:0] F3_OR   = 3'b110;
  localparam logic [2:0] F3_AND  = 3'b111;

  localparam int OP_ALT_BIT  = 3;
  localparam int OP_RSVD_BIT = 4;

  localparam logic [4:0] ECAUSE_NONE       = 5'd0;
  localparam logic [4:0] ECAUSE_ILLEGAL_OP = 5'd2;

  // Status fields of the result bundle. The width-dependent fields
  // (robid, rd, result) are appended by the top, which owns the widths.
  typedef struct packed {
    logic       error;
    logic [4:0] ecause;
  } scalu_status_t;

  // The alt bit only has a meaning for ADD/SUB and SRL/SRA.
  function automatic logic is_illegal(input logic [4:0] op);
    return op[OP_RSVD_BIT] |
           (op[OP_ALT_BIT] & (op[2:0] != F3_ADD) & (op[2:0] != F3_SR));
  endfunction

endpackage

// File: rtl/scalu_outq.sv
// scalu_outq: small synchronous FIFO holding completed ALU results.
// Ports:
//   clk    in   clock
//   clear  in   synchronous clear (empties the queue, pointers to 0)
//   push   in   write din this cycle (ignored when full without a pop)
//   din    in   entry to write
//   pop    in   remove head this cycle (ignored when empty)
//   full   out  DEPTH entries held
//   empty  out  no entries held
//   head   out  oldest entry; stable until popped
module scalu_outq #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 2
) (
  input  logic             clk,
  input  logic             clear,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic             full,
  output logic             empty,
  output logic [WIDTH-1:0] head
);

  localparam int PW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic [PW:0]      count;
  logic             do_push;
  logic             do_pop;

  assign empty   = (count == '0);
  assign full    = (count == (PW+1)'(DEPTH));
  assign do_pop  = pop & ~empty;
  // A push into a full queue is fine when the head leaves the same edge.
  assign do_push = push & (~full | do_pop);
  assign head    = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (clear) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      count <= count + (PW+1)'(do_push) - (PW+1)'(do_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/scalu_pipe.sv
// scalu_pipe: scalar integer ALU between the issue port and writeback.
// One op is latched per cycle into stage S1, evaluated combinationally,
// and pushed into an output FIFO that absorbs writeback back-pressure.
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   exers_scalu_issue   issue valid (taken when scalu_stall=0)
//   exers_scalu_op      op code {rsvd, alt, funct3}
//   exers_robid/rd      ROB tag / destination tag of the issued op
//   exers_op1/op2       operands
//   scalu_stall         issue back-pressure
//   scalu_valid         FIFO head valid
//   scalu_error/ecause  head op was illegal / its cause
//   scalu_robid/rd      head tags
//   scalu_result        head result
//   wb_scalu_stall      writeback not taking the head this cycle
//   rob_flush           discard everything in flight
module scalu_pipe
  import scalu_pkg::*;
#(
  parameter int XLEN       = 32,
  parameter int ROBID_W    = 8,
  parameter int RD_W       = 6,
  parameter int OUTQ_DEPTH = 2
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               exers_scalu_issue,
  input  logic [4:0]         exers_scalu_op,
  input  logic [ROBID_W-1:0] exers_robid,
  input  logic [RD_W-1:0]    exers_rd,
  input  logic [XLEN-1:0]    exers_op1,
  input  logic [XLEN-1:0]    exers_op2,
  output logic               scalu_stall,
  output logic               scalu_valid,
  output logic               scalu_error,
  output logic [4:0]         scalu_ecause,
  output logic [ROBID_W-1:0] scalu_robid,
  output logic [RD_W-1:0]    scalu_rd,
  output logic [XLEN-1:0]    scalu_result,
  input  logic               wb_scalu_stall,
  input  logic               rob_flush
);

  localparam int SHW = $clog2(XLEN);

  typedef struct packed {
    scalu_status_t      status;
    logic [ROBID_W-1:0] robid;
    logic [RD_W-1:0]    rd;
    logic [XLEN-1:0]    result;
  } res_t;

  logic               clear;
  logic               s1_valid;
  logic [4:0]         s1_op;
  logic [ROBID_W-1:0] s1_robid;
  logic [RD_W-1:0]    s1_rd;
  logic [XLEN-1:0]    s1_op1;
  logic [XLEN-1:0]    s1_op2;

  logic               pop;
  logic               advance;
  logic               accept;
  logic               q_full;
  logic               q_empty;
  logic [XLEN-1:0]    alu;
  logic [SHW-1:0]     shamt;
  logic               illegal;
  res_t               s1_res;
  res_t               head;

  assign clear       = rst | rob_flush;
  assign pop         = scalu_valid & ~wb_scalu_stall;
  assign advance     = s1_valid & (~q_full | pop);
  // Built only from registered state and wb, never from the issue inputs.
  assign scalu_stall = s1_valid & ~advance;
  assign accept      = exers_scalu_issue & ~scalu_stall;

  always_ff @(posedge clk) begin
    if (clear) begin
      s1_valid <= 1'b0;
    end else if (accept) begin
      s1_valid <= 1'b1;
    end else if (advance) begin
      s1_valid <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (accept) begin
      s1_op    <= exers_scalu_op;
      s1_robid <= exers_robid;
      s1_rd    <= exers_rd;
      s1_op1   <= exers_op1;
      s1_op2   <= exers_op2;
    end
  end

  always_comb begin
    alu   = '0;
    shamt = s1_op2[SHW-1:0];
    case (s1_op[2:0])
      F3_ADD:  alu = s1_op[OP_ALT_BIT] ? (s1_op1 - s1_op2) : (s1_op1 + s1_op2);
      F3_SLL:  alu = s1_op1 << shamt;
      F3_SLT:  alu = XLEN'($signed(s1_op1) < $signed(s1_op2));
      F3_SLTU: alu = XLEN'(s1_op1 < s1_op2);
      F3_XOR:  alu = s1_op1 ^ s1_op2;
      F3_SR:   alu = s1_op[OP_ALT_BIT] ? XLEN'($signed(s1_op1) >>> shamt)
                                       : (s1_op1 >> shamt);
      F3_OR:   alu = s1_op1 | s1_op2;
      F3_AND:  alu = s1_op1 & s1_op2;
    endcase
  end

  always_comb begin
    illegal              = is_illegal(s1_op);
    s1_res.status.error  = illegal;
    s1_res.status.ecause = illegal ? ECAUSE_ILLEGAL_OP : ECAUSE_NONE;
    s1_res.robid         = s1_robid;
    s1_res.rd            = s1_rd;
    s1_res.result        = illegal ? '0 : alu;
  end

  scalu_outq #(
    .WIDTH ($bits(res_t)),
    .DEPTH (OUTQ_DEPTH)
  ) u_outq (
    .clk   (clk),
    .clear (clear),
    .push  (advance),
    .din   (s1_res),
    .pop   (pop),
    .full  (q_full),
    .empty (q_empty),
    .head  (head)
  );

  // FIFO storage is not reset, so the status outputs are gated to give
  // clean zeros whenever the queue is empty.
  assign scalu_valid  = ~q_empty;
  assign scalu_error  = ~q_empty & head.status.error;
  assign scalu_ecause = q_empty ? ECAUSE_NONE : head.status.ecause;
  assign scalu_robid  = head.robid;
  assign scalu_rd     = head.rd;
  assign scalu_result = head.result;

endmodule

// File: tb/tb_scalu_pipe.sv
module tb_scalu_pipe;

  localparam int XLEN       = 32;
  localparam int ROBID_W    = 8;
  localparam int RD_W       = 6;
  localparam int OUTQ_DEPTH = 2;

  logic               clk = 1'b0;
  logic               rst;
  logic               exers_scalu_issue;
  logic [4:0]         exers_scalu_op;
  logic [ROBID_W-1:0] exers_robid;
  logic [RD_W-1:0]    exers_rd;
  logic [XLEN-1:0]    exers_op1;
  logic [XLEN-1:0]    exers_op2;
  logic               scalu_stall;
  logic               scalu_valid;
  logic               scalu_error;
  logic [4:0]         scalu_ecause;
  logic [ROBID_W-1:0] scalu_robid;
  logic [RD_W-1:0]    scalu_rd;
  logic [XLEN-1:0]    scalu_result;
  logic               wb_scalu_stall;
  logic               rob_flush;

  always #5 clk = ~clk;

  scalu_pipe #(
    .XLEN(XLEN), .ROBID_W(ROBID_W), .RD_W(RD_W), .OUTQ_DEPTH(OUTQ_DEPTH)
  ) dut (
    .clk(clk), .rst(rst),
    .exers_scalu_issue(exers_scalu_issue), .exers_scalu_op(exers_scalu_op),
    .exers_robid(exers_robid), .exers_rd(exers_rd),
    .exers_op1(exers_op1), .exers_op2(exers_op2),
    .scalu_stall(scalu_stall), .scalu_valid(scalu_valid),
    .scalu_error(scalu_error), .scalu_ecause(scalu_ecause),
    .scalu_robid(scalu_robid), .scalu_rd(scalu_rd), .scalu_result(scalu_result),
    .wb_scalu_stall(wb_scalu_stall), .rob_flush(rob_flush)
  );

  typedef struct {
    logic [XLEN-1:0]    res;
    logic               err;
    logic [4:0]         ec;
    logic [ROBID_W-1:0] robid;
    logic [RD_W-1:0]    rd;
    int                 acc_cyc;
  } exp_t;

  exp_t exp_q[$];
  int   cyc    = 0;
  int   nchk   = 0;
  int   npass  = 0;
  int   n_acc  = 0;
  int   n_pops = 0;

  // Reference ALU written straight from the op table.
  function automatic void ref_op(input logic [4:0] op, input logic [XLEN-1:0] a,
                                 input logic [XLEN-1:0] b, output logic [XLEN-1:0] r,
                                 output logic e, output logic [4:0] ec);
    int sh;
    sh = int'(b % XLEN);
    r  = '0;
    e  = 1'b0;
    ec = 5'd0;
    case (op)
      5'd0:  r = a + b;
      5'd8:  r = a - b;
      5'd1:  r = a << sh;
      5'd2:  r = {{(XLEN-1){1'b0}}, ($signed(a) < $signed(b))};
      5'd3:  r = {{(XLEN-1){1'b0}}, (a < b)};
      5'd4:  r = a ^ b;
      5'd5:  r = a >> sh;
      5'd13: begin
        r = a >> sh;
        if (a[XLEN-1]) r = r | ~({XLEN{1'b1}} >> sh);
      end
      5'd6:  r = a | b;
      5'd7:  r = a & b;
      default: begin
        e  = 1'b1;
        ec = 5'd2;
      end
    endcase
  endfunction

  // One clock cycle: drive inputs, check outputs against the model,
  // update the model with the handshakes that happen at the coming edge.
  task automatic cycle(input bit iss, input logic [4:0] op, input logic [XLEN-1:0] a,
                       input logic [XLEN-1:0] b, input logic [ROBID_W-1:0] robid,
                       input logic [RD_W-1:0] rd, input bit wbst, input bit fl, input bit rs);
    bit   valid_exp, pop_exp, stall_exp;
    exp_t e;
    exers_scalu_issue = iss;
    exers_scalu_op    = op;
    exers_op1         = a;
    exers_op2         = b;
    exers_robid       = robid;
    exers_rd          = rd;
    wb_scalu_stall    = wbst;
    rob_flush         = fl;
    rst               = rs;
    #1;
    // An op shows at the head one edge after acceptance once all older ops are gone.
    valid_exp = (exp_q.size() > 0) && (exp_q[0].acc_cyc < cyc);
    pop_exp   = valid_exp && !wbst;
    stall_exp = (exp_q.size() == OUTQ_DEPTH + 1) && !pop_exp;

    nchk++;
    if (scalu_valid !== valid_exp)
      $display("FAIL valid cyc=%0d got=%b exp=%b", cyc, scalu_valid, valid_exp);
    else npass++;

    nchk++;
    if (scalu_stall !== stall_exp)
      $display("FAIL stall cyc=%0d got=%b exp=%b", cyc, scalu_stall, stall_exp);
    else npass++;

    if (valid_exp) begin
      nchk++;
      if (scalu_error !== exp_q[0].err || scalu_ecause !== exp_q[0].ec ||
          scalu_robid !== exp_q[0].robid || scalu_rd !== exp_q[0].rd ||
          scalu_result !== exp_q[0].res)
        $display("FAIL head cyc=%0d got err=%b ec=%0d robid=%h rd=%h res=%h exp err=%b ec=%0d robid=%h rd=%h res=%h",
                 cyc, scalu_error, scalu_ecause, scalu_robid, scalu_rd, scalu_result,
                 exp_q[0].err, exp_q[0].ec, exp_q[0].robid, exp_q[0].rd, exp_q[0].res);
      else npass++;
    end

    if (rs || fl) begin
      exp_q.delete();
    end else begin
      if (pop_exp) begin
        void'(exp_q.pop_front());
        n_pops++;
      end
      if (iss && !stall_exp) begin
        ref_op(op, a, b, e.res, e.err, e.ec);
        e.robid   = robid;
        e.rd      = rd;
        e.acc_cyc = cyc + 1;
        exp_q.push_back(e);
        n_acc++;
      end
    end
    @(posedge clk);
    cyc++;
    #1;
  endtask

  task automatic idle(input int n, input bit wbst);
    for (int i = 0; i < n; i++) cycle(0, 5'd0, '0, '0, '0, '0, wbst, 0, 0);
  endtask

  task automatic issue(input logic [4:0] op, input logic [XLEN-1:0] a,
                       input logic [XLEN-1:0] b, input logic [ROBID_W-1:0] robid);
    cycle(1, op, a, b, robid, RD_W'(robid), 0, 0, 0);
  endtask

  task automatic test_reset();
    exers_scalu_issue = 1'b1;
    exers_scalu_op    = 5'd0;
    exers_op1         = '0;
    exers_op2         = '0;
    exers_robid       = '0;
    exers_rd          = '0;
    wb_scalu_stall    = 1'b0;
    rob_flush         = 1'b0;
    rst               = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    nchk++;
    if (scalu_valid !== 1'b0) $display("FAIL reset_valid got=%b exp=0", scalu_valid);
    else npass++;
    nchk++;
    if (scalu_stall !== 1'b0) $display("FAIL reset_stall got=%b exp=0", scalu_stall);
    else npass++;
    nchk++;
    if (scalu_error !== 1'b0) $display("FAIL reset_error got=%b exp=0", scalu_error);
    else npass++;
    nchk++;
    if (scalu_ecause !== 5'd0) $display("FAIL reset_ecause got=%0d exp=0", scalu_ecause);
    else npass++;
    exers_scalu_issue = 1'b0;
    rst               = 1'b0;
    exp_q.delete();
  endtask

  task automatic test_add_sub();
    issue(5'd0, {XLEN{1'b1}}, XLEN'(1), 8'h01);
    issue(5'd8, XLEN'(5), XLEN'(7), 8'h02);
    idle(3, 0);
  endtask

  task automatic test_shifts();
    issue(5'd1, XLEN'(1), XLEN'(35), 8'h10);
    issue(5'd5, XLEN'(1) << (XLEN-1), XLEN'(4), 8'h11);
    issue(5'd13, XLEN'(1) << (XLEN-1), XLEN'(4), 8'h12);
    issue(5'd5, {XLEN{1'b1}}, XLEN'(XLEN + 1), 8'h13);
    idle(3, 0);
  endtask

  task automatic test_compare_illegal();
    issue(5'd2, {XLEN{1'b1}}, XLEN'(1), 8'h20);
    issue(5'd3, {XLEN{1'b1}}, XLEN'(1), 8'h21);
    issue(5'b10000, XLEN'(3), XLEN'(4), 8'h2A);
    issue(5'b01100, XLEN'(3), XLEN'(4), 8'h2B);
    issue(5'b01001, XLEN'(3), XLEN'(4), 8'h2C);
    idle(3, 0);
  endtask

  task automatic test_back_to_back();
    int acc_before;
    acc_before = n_acc;
    for (int i = 0; i < 6; i++)
      cycle(1, 5'(i % 8), XLEN'($urandom), XLEN'($urandom), ROBID_W'(8'h40 + i),
            RD_W'(i), 1, 0, 0);
    nchk++;
    if (n_acc - acc_before != OUTQ_DEPTH + 1 || scalu_stall !== 1'b1)
      $display("FAIL backpressure_accepts got=%0d stall=%b exp=%0d stall=1",
               n_acc - acc_before, scalu_stall, OUTQ_DEPTH + 1);
    else npass++;
    idle(6, 0);
  endtask

  task automatic fill_then_clear(input bit use_rst);
    for (int i = 0; i < OUTQ_DEPTH + 2; i++)
      cycle(1, 5'd0, XLEN'(i), XLEN'(100), ROBID_W'(8'h50 + i), RD_W'(i), 1, 0, 0);
    cycle(1, 5'd4, XLEN'(7), XLEN'(7), 8'h5F, 6'h1F, 1, !use_rst, use_rst);
    nchk++;
    if (scalu_error !== 1'b0) $display("FAIL clear_error got=%b exp=0", scalu_error);
    else npass++;
    cycle(0, 5'd0, '0, '0, '0, '0, 1, 0, 0);
    issue(5'd6, XLEN'(8'hF0), XLEN'(8'h0F), 8'h60);
    idle(4, 0);
  endtask

  task automatic test_flush();
    fill_then_clear(0);
  endtask

  task automatic test_reset_mid();
    fill_then_clear(1);
  endtask

  task automatic test_random();
    logic [XLEN-1:0] a, b;
    for (int i = 0; i < 400; i++) begin
      a = XLEN'($urandom);
      b = XLEN'($urandom);
      if ($urandom_range(0, 7) == 0) a = {1'b1, {(XLEN-1){1'b0}}};
      if ($urandom_range(0, 7) == 0) b = {XLEN{1'b1}};
      cycle($urandom_range(0, 3) != 0, 5'($urandom_range(0, 31)), a, b,
            ROBID_W'($urandom), RD_W'($urandom), $urandom_range(0, 2) == 0,
            $urandom_range(0, 59) == 0, 0);
    end
  endtask

  task automatic drain();
    int budget;
    budget = 0;
    while (exp_q.size() > 0 && budget < 40) begin
      idle(1, 0);
      budget++;
    end
    nchk++;
    if (exp_q.size() != 0) $display("FAIL drain_timeout left=%0d exp=0", exp_q.size());
    else npass++;
  endtask

  initial begin
    test_reset();
    test_add_sub();
    test_shifts();
    test_compare_illegal();
    test_back_to_back();
    test_flush();
    test_reset_mid();
    test_random();
    drain();
    $display("%0d/%0d checks passed", npass, nchk);
    $finish;
  end

endmodule
